// File: rtl/pwm_duty_sequencer_if.sv
// -----------------------------------------------------------------------------
// pwm_duty_sequencer_if
// Groups the button / mode inputs and the duty outputs of pwm_duty_sequencer.
//   inc_req  : raw increase pushbutton (asynchronous, active-high)
//   dec_req  : raw decrease pushbutton (asynchronous, active-high)
//   ramp_en  : mode select, 1 = automatic ramp, 0 = manual (synchronous)
//   duty_out : duty code delivered to the PWM generator
//   duty_upd : one-cycle pulse in the cycle duty_out takes a new value
//   ramp_dir : current ramp direction, 1 = up, 0 = down
// master drives the requests, slave (the sequencer) drives the duty outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface pwm_duty_sequencer_if #(
  parameter int DUTY_W = 4
);
  logic              inc_req;
  logic              dec_req;
  logic              ramp_en;
  logic [DUTY_W-1:0] duty_out;
  logic              duty_upd;
  logic              ramp_dir;

  modport master (
    output inc_req, dec_req, ramp_en,
    input  duty_out, duty_upd, ramp_dir
  );

  modport slave (
    input  inc_req, dec_req, ramp_en,
    output duty_out, duty_upd, ramp_dir
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_duty_sequencer
// Produces the duty code for a PWM generator. Manual inc/dec pushbuttons are
// synchronised (2 FF), debounced and edge-detected; an automatic triangular
// fade ramp takes over while ramp_en is high. Manual steps saturate at 0 and
// DUTY_MAX; ramp steps bounce between them.
//
// Optional feature: define PWM_DUTY_WRAP_EN to make manual steps wrap
// (inc from DUTY_MAX -> 0, dec from 0 -> DUTY_MAX). Ramp mode is unaffected.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : pwm_duty_sequencer_if.slave (inc_req, dec_req, ramp_en in;
//           duty_out, duty_upd, ramp_dir out)
//
// Latency: a clean press asserted before edge k updates duty_out at edge
// k+DEBOUNCE_LIMIT+3 (2 sync + DEBOUNCE_LIMIT debounce + press reg + duty reg).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pwm_duty_sequencer #(
  parameter int DUTY_MAX       = 10,
  parameter int DUTY_INIT      = 5,
  parameter int STEP           = 1,
  parameter int DEBOUNCE_LIMIT = 10,
  parameter int RAMP_DIV       = 1000,
  parameter int DUTY_W         = $clog2(DUTY_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_duty_sequencer_if.slave   bus
);

  localparam int CNT_W  = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int TICK_W = $clog2(RAMP_DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [DUTY_W-1:0] MAX_C     = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_C    = DUTY_W'(DUTY_INIT);
  localparam logic [DUTY_W-1:0] ZERO_C    = {DUTY_W{1'b0}};
  localparam logic [DUTY_W:0]   MAX_X     = (DUTY_W + 1)'(DUTY_MAX);
  localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } state_t;

  // Saturating step up, computed one bit wider so the carry is visible.
  function automatic logic [DUTY_W-1:0] sat_up(input logic [DUTY_W-1:0] d);
    logic [DUTY_W:0] sum;
    sum = {1'b0, d} + STEP_X;
    if (sum > MAX_X) sat_up = MAX_C;
    else             sat_up = sum[DUTY_W-1:0];
  endfunction

  // Saturating step down, never underflows below zero.
  function automatic logic [DUTY_W-1:0] sat_dn(input logic [DUTY_W-1:0] d);
    logic [DUTY_W:0] diff;
    diff = {1'b0, d} - STEP_X;
    if ({1'b0, d} < STEP_X) sat_dn = ZERO_C;
    else                    sat_dn = diff[DUTY_W-1:0];
  endfunction

  // Manual increment: wraps at full scale when the wrap option is built in.
  function automatic logic [DUTY_W-1:0] man_up(input logic [DUTY_W-1:0] d);
`ifdef PWM_DUTY_WRAP_EN
    if (d == MAX_C) man_up = ZERO_C;
    else            man_up = sat_up(d);
`else
    man_up = sat_up(d);
`endif
  endfunction

  // Manual decrement: wraps at zero when the wrap option is built in.
  function automatic logic [DUTY_W-1:0] man_dn(input logic [DUTY_W-1:0] d);
`ifdef PWM_DUTY_WRAP_EN
    if (d == ZERO_C) man_dn = MAX_C;
    else             man_dn = sat_dn(d);
`else
    man_dn = sat_dn(d);
`endif
  endfunction

  // Button front end; index 0 = inc, index 1 = dec.
  logic [1:0]       btn_raw_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       deb_r;
  logic [1:0]       deb_prev_r;
  logic [1:0]       press_r;
  logic [CNT_W-1:0] cnt_r [2];

  // Sequencer state.
  state_t            state_r;
  state_t            state_s;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_s;
  logic [TICK_W-1:0] tick_r;
  logic [TICK_W-1:0] tick_s;
  logic              upd_r;
  logic              dir_r;
  logic [DUTY_W-1:0] ramp_up_val_s;
  logic [DUTY_W-1:0] ramp_dn_val_s;

  assign btn_raw_s = {bus.dec_req, bus.inc_req};

  // Synchronise, debounce and edge-detect both pushbuttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= 2'b00;
      sync2_r    <= 2'b00;
      deb_r      <= 2'b00;
      deb_prev_r <= 2'b00;
      press_r    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r    <= btn_raw_s;
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_r;
      // Registered rising edge of the debounced level: one pulse per press.
      press_r    <= deb_r & ~deb_prev_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  assign ramp_up_val_s = sat_up(duty_r);
  assign ramp_dn_val_s = sat_dn(duty_r);

  // Next-state, next-duty and tick counter logic.
  always_comb begin
    state_s = state_r;
    duty_s  = duty_r;
    tick_s  = tick_r;
    case (state_r)
      ST_MANUAL: begin
        // Counter held clear so every ramp starts a full period after entry.
        tick_s = TICK_ZERO;
        // Mode change wins over a coincident press.
        if (bus.ramp_en) begin
          if (duty_r == MAX_C) state_s = ST_RAMP_DOWN;
          else                 state_s = ST_RAMP_UP;
        end else if (press_r[0] && !press_r[1]) begin
          duty_s = man_up(duty_r);
        end else if (press_r[1] && !press_r[0]) begin
          duty_s = man_dn(duty_r);
        end else begin
          duty_s = duty_r;
        end
      end
      ST_RAMP_UP: begin
        if (!bus.ramp_en) begin
          state_s = ST_MANUAL;
          tick_s  = TICK_ZERO;
        end else if (tick_r == TICK_LAST) begin
          tick_s = TICK_ZERO;
          duty_s = ramp_up_val_s;
          if (ramp_up_val_s == MAX_C) state_s = ST_RAMP_DOWN;
          else                        state_s = ST_RAMP_UP;
        end else begin
          tick_s = tick_r + TICK_ONE;
        end
      end
      ST_RAMP_DOWN: begin
        if (!bus.ramp_en) begin
          state_s = ST_MANUAL;
          tick_s  = TICK_ZERO;
        end else if (tick_r == TICK_LAST) begin
          tick_s = TICK_ZERO;
          duty_s = ramp_dn_val_s;
          if (ramp_dn_val_s == ZERO_C) state_s = ST_RAMP_UP;
          else                         state_s = ST_RAMP_DOWN;
        end else begin
          tick_s = tick_r + TICK_ONE;
        end
      end
      default: begin
        state_s = ST_MANUAL;
        tick_s  = TICK_ZERO;
        duty_s  = duty_r;
      end
    endcase
  end

  // State, duty and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_MANUAL;
      duty_r  <= INIT_C;
      tick_r  <= TICK_ZERO;
      upd_r   <= 1'b0;
      dir_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      duty_r  <= duty_s;
      tick_r  <= tick_s;
      // Saturated no-ops leave duty unchanged and therefore give no pulse.
      upd_r   <= (duty_s != duty_r);
      dir_r   <= (state_s != ST_RAMP_DOWN);
    end
  end

  assign bus.duty_out = duty_r;
  assign bus.duty_upd = upd_r;
  assign bus.ramp_dir = dir_r;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_sequencer
// Self-checking bench for pwm_duty_sequencer (RAMP_DIV overridden to 4).
// A behavioural model (run-length debounce, press latency, mode/duty rules)
// is compared against the DUT every cycle; directed sections pin the model
// with hand-computed values; a randomized section follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_duty_sequencer;

  localparam int DUTY_MAX  = 10;
  localparam int DUTY_INIT = 5;
  localparam int STEP      = 1;
  localparam int DEB_LIM   = 10;
  localparam int RAMP_DIV  = 4;
  localparam int DUTY_W    = $clog2(DUTY_MAX + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_duty_sequencer_if #(.DUTY_W(DUTY_W)) bus ();

  pwm_duty_sequencer #(
    .DUTY_MAX      (DUTY_MAX),
    .DUTY_INIT     (DUTY_INIT),
    .STEP          (STEP),
    .DEBOUNCE_LIMIT(DEB_LIM),
    .RAMP_DIV      (RAMP_DIV),
    .DUTY_W        (DUTY_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp        = 0;
  int n_bad        = 0;
  int cyc          = 0;
  int upd_cnt      = 0;
  int last_upd_cyc = -1;
  int k0           = 0;
  int k_tmp        = 0;
  int hold_i       = 0;
  int hold_d       = 0;
  int hold_r       = 0;

  // Behavioural model state
  int m_duty;
  bit m_upd;
  bit m_ramping;
  bit m_up;
  int m_phase;
  bit m_d1  [2];
  bit m_d2  [2];
  bit m_deb [2];
  bit m_r1  [2];
  bit m_r2  [2];
  int m_run [2];

  function automatic int man_inc(input int d);
`ifdef PWM_DUTY_WRAP_EN
    if (d == DUTY_MAX) return 0;
`endif
    return (d + STEP > DUTY_MAX) ? DUTY_MAX : d + STEP;
  endfunction

  function automatic int man_dec(input int d);
`ifdef PWM_DUTY_WRAP_EN
    if (d == 0) return DUTY_MAX;
`endif
    return (d - STEP < 0) ? 0 : d - STEP;
  endfunction

  task automatic model_reset();
    m_duty    = DUTY_INIT;
    m_upd     = 1'b0;
    m_ramping = 1'b0;
    m_up      = 1'b1;
    m_phase   = 0;
    for (int b = 0; b < 2; b++) begin
      m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_deb[b] = 1'b0;
      m_r1[b] = 1'b0; m_r2[b] = 1'b0; m_run[b] = 0;
    end
  endtask

  // One clock edge of the model, with the inputs sampled at that edge.
  task automatic model_edge(input bit inc, input bit dec, input bit ren);
    bit btn  [2];
    bit fire [2];
    bit x;
    int prev;
    btn[0] = inc;
    btn[1] = dec;
    for (int b = 0; b < 2; b++) begin
      // A debounced rise becomes effective on duty two edges later.
      fire[b] = m_r2[b];
      m_r2[b] = m_r1[b];
      m_r1[b] = 1'b0;
      // Synchronised view of the button is its value two edges ago.
      x       = m_d2[b];
      m_d2[b] = m_d1[b];
      m_d1[b] = btn[b];
      // Debounced level flips after DEB_LIM consecutive disagreeing samples.
      if (x != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB_LIM) begin
          m_deb[b] = x;
          m_run[b] = 0;
          m_r1[b]  = x;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    prev = m_duty;
    if (!m_ramping) begin
      if (ren) begin
        m_ramping = 1'b1;
        m_up      = (m_duty != DUTY_MAX);
        m_phase   = 0;
      end else if (fire[0] && !fire[1]) begin
        m_duty = man_inc(m_duty);
      end else if (fire[1] && !fire[0]) begin
        m_duty = man_dec(m_duty);
      end
    end else if (!ren) begin
      m_ramping = 1'b0;
    end else begin
      m_phase++;
      if (m_phase == RAMP_DIV) begin
        m_phase = 0;
        if (m_up) begin
          m_duty = (m_duty + STEP > DUTY_MAX) ? DUTY_MAX : m_duty + STEP;
          if (m_duty == DUTY_MAX) m_up = 1'b0;
        end else begin
          m_duty = (m_duty - STEP < 0) ? 0 : m_duty - STEP;
          if (m_duty == 0) m_up = 1'b1;
        end
      end
    end
    m_upd = (m_duty != prev);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_all();
    check("duty_out", 32'(bus.duty_out), 32'(m_duty));
    check("duty_upd", 32'(bus.duty_upd), 32'(m_upd));
    check("ramp_dir", 32'(bus.ramp_dir), 32'(!(m_ramping && !m_up)));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(bus.inc_req, bus.dec_req, bus.ramp_en);
    #1;
    if (bus.duty_upd === 1'b1) begin
      upd_cnt++;
      last_upd_cyc = cyc;
    end
    cmp_all();
  endtask

  task automatic do_reset();
    bus.inc_req = 1'b0;
    bus.dec_req = 1'b0;
    bus.ramp_en = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_all();
    repeat (3) tick();
    rst_n   = 1'b1;
    upd_cnt = 0;
  endtask

  // Clean press: high for 10 cycles then low for 10; k = edge index of start.
  task automatic press(input int b, output int k);
    if (b == 0) bus.inc_req = 1'b1; else bus.dec_req = 1'b1;
    tick();
    k = cyc;
    repeat (9) tick();
    bus.inc_req = 1'b0;
    bus.dec_req = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    bus.inc_req = 1'b0;
    bus.dec_req = 1'b0;
    bus.ramp_en = 1'b0;
    model_reset();
    repeat (2) tick();
    do_reset();

    // Reset values, then idle stability.
    check("rst_duty", 32'(bus.duty_out), 32'd5);
    check("rst_upd",  32'(bus.duty_upd), 32'd0);
    check("rst_dir",  32'(bus.ramp_dir), 32'd1);
    repeat (50) tick();
    check("idle_duty", 32'(bus.duty_out), 32'd5);
    check("idle_upd_cnt", 32'(upd_cnt), 32'd0);

    // Manual steps: 3 up then 3 down.
    last_upd_cyc = -1;
    press(0, k0);
    check("press_latency", 32'(last_upd_cyc - k0), 32'd13);
    press(0, k_tmp);
    press(0, k_tmp);
    check("inc3_duty", 32'(bus.duty_out), 32'd8);
    check("inc3_upd_cnt", 32'(upd_cnt), 32'd3);
    repeat (3) press(1, k_tmp);
    check("dec3_duty", 32'(bus.duty_out), 32'd5);
    check("dec3_upd_cnt", 32'(upd_cnt), 32'd6);

    // Glitches shorter than the debounce window.
    upd_cnt = 0;
    repeat (4) begin
      bus.inc_req = 1'b1; repeat (5) tick();
      bus.inc_req = 1'b0; repeat (5) tick();
    end
    repeat (15) tick();
    check("glitch_duty", 32'(bus.duty_out), 32'd5);
    check("glitch_upd_cnt", 32'(upd_cnt), 32'd0);

    // Saturation (or wrap) at the top.
    do_reset();
    repeat (7) press(0, k_tmp);
`ifdef PWM_DUTY_WRAP_EN
    check("sat_hi_duty", 32'(bus.duty_out), 32'd1);
    check("sat_hi_upd_cnt", 32'(upd_cnt), 32'd7);
`else
    check("sat_hi_duty", 32'(bus.duty_out), 32'd10);
    check("sat_hi_upd_cnt", 32'(upd_cnt), 32'd5);
`endif

    // Saturation (or wrap) at the bottom.
    do_reset();
    repeat (7) press(1, k_tmp);
`ifdef PWM_DUTY_WRAP_EN
    check("sat_lo_duty", 32'(bus.duty_out), 32'd9);
    check("sat_lo_upd_cnt", 32'(upd_cnt), 32'd7);
`else
    check("sat_lo_duty", 32'(bus.duty_out), 32'd0);
    check("sat_lo_upd_cnt", 32'(upd_cnt), 32'd5);
`endif

    // Simultaneous inc and dec.
    do_reset();
    bus.inc_req = 1'b1;
    bus.dec_req = 1'b1;
    repeat (20) tick();
    bus.inc_req = 1'b0;
    bus.dec_req = 1'b0;
    repeat (20) tick();
    check("simul_duty", 32'(bus.duty_out), 32'd5);
    check("simul_upd_cnt", 32'(upd_cnt), 32'd0);

    // Ramp from 5: +1 every 4 cycles up to 10, down to 0, back up to 3.
    do_reset();
    bus.ramp_en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.inc_req = (i >= 2 && i < 14);
      tick();
    end
    check("ramp_top_duty", 32'(bus.duty_out), 32'd10);
    check("ramp_top_dir",  32'(bus.ramp_dir), 32'd0);
    for (int i = 0; i < 40; i++) begin
      bus.dec_req = (i >= 5 && i < 20);
      tick();
    end
    check("ramp_bot_duty", 32'(bus.duty_out), 32'd0);
    check("ramp_bot_dir",  32'(bus.ramp_dir), 32'd1);
    repeat (12) tick();
    check("ramp_3_duty", 32'(bus.duty_out), 32'd3);
    bus.ramp_en = 1'b0;
    repeat (20) tick();
    check("ramp_hold_duty", 32'(bus.duty_out), 32'd3);

    // Randomized traffic against the model, with one async reset midway.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if (hold_i == 0) begin
        bus.inc_req = ($urandom_range(0, 1) == 1);
        hold_i = $urandom_range(1, 30);
      end
      if (hold_d == 0) begin
        bus.dec_req = ($urandom_range(0, 1) == 1);
        hold_d = $urandom_range(1, 30);
      end
      if (hold_r == 0) begin
        bus.ramp_en = ($urandom_range(0, 3) == 0);
        hold_r = $urandom_range(20, 200);
      end
      hold_i--;
      hold_d--;
      hold_r--;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Controller that produces the duty setting for the PWM generator and sequences changes to it.
- Arbitrates between manual inc/dec pushbuttons (synchronised, debounced, edge-detected) and an automatic triangular fade ramp.
- Output duty_out drives the PWM generator's duty input directly; the PWM counter stays in the generator.

Parameters:
- DUTY_MAX, 10, full-scale duty code (10 = 100 %, one code = 10 %)
- DUTY_INIT, 5, duty_out value after reset; must be ≤ DUTY_MAX
- STEP, 1, duty codes added or removed per manual press or ramp tick; must be ≥ 1
- DEBOUNCE_LIMIT, 10, consecutive stable cycles required to accept a button level change; must be ≥ 1
- RAMP_DIV, 1000, clock cycles between ramp steps; must be ≥ 2
- DUTY_W, $clog2(DUTY_MAX+1), width of duty_out (derived; do not override)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- inc_req  in  1  raw increase pushbutton, asynchronous, active-high
- dec_req  in  1  raw decrease pushbutton, asynchronous, active-high
- ramp_en  in  1  synchronous mode select: 1 = automatic ramp, 0 = manual
- duty_out  out  DUTY_W  duty code delivered to the PWM generator
- duty_upd  out  1  one-cycle pulse in the cycle duty_out takes a new value
- ramp_dir  out  1  current ramp direction: 1 = up, 0 = down; valid in ramp mode

Behaviour:
- Reset (rst_n low, asynchronous):
  - duty_out=DUTY_INIT, duty_upd=0, ramp_dir=1, FSM=MANUAL.
  - All synchroniser, debounce and tick counters clear; debounced levels = 0.
- Per button input:
  - 2-FF synchroniser.
  - Debounce counter counts while the synchronised level ≠ debounced level, and clears when they are equal.
  - When the count reaches DEBOUNCE_LIMIT-1 with the mismatch still present, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a 1-cycle press pulse.
  - A clean press asserted before edge k updates duty_out at edge k+DEBOUNCE_LIMIT+3. This is 13 cycles at default.
  - Holding a button produces exactly one step; release needs no action.
  - Glitches shorter than DEBOUNCE_LIMIT cycles are ignored.
- Arithmetic is computed at DUTY_W+1 bits and saturates:
  - inc: min(duty+STEP, DUTY_MAX).
  - dec: max(duty-STEP, 0), with no underflow.
- duty_upd fires only if the value actually changes; a saturated no-op gives no pulse.
- FSM states: MANUAL, RAMP_UP, RAMP_DOWN.
- MANUAL:
  - inc press → step up; dec press → step down.
  - inc and dec press pulses in the same cycle → no change.
  - ramp_en=1 → RAMP_DOWN if duty_out==DUTY_MAX, otherwise RAMP_UP.
  - The tick counter clears on entry.
- RAMP_UP / RAMP_DOWN:
  - Tick counter counts 0..RAMP_DIV-1; at terminal count duty steps by STEP in the current direction.
  - RAMP_UP switches to RAMP_DOWN in the same cycle duty_out reaches DUTY_MAX.
  - RAMP_DOWN switches to RAMP_UP when duty_out reaches 0.
  - ramp_dir mirrors the state.
  - Manual press pulses are discarded, but the debouncers keep tracking the buttons.
  - ramp_en=0 → MANUAL next cycle: duty_out holds its current value and the tick counter clears.
- Reset asserted mid-ramp or mid-debounce aborts immediately to the reset values.
- ramp_en is sampled synchronously and is not synchronised inside the block.

Optional Feature:
- Macro PWM_DUTY_WRAP_EN.
- When defined, manual steps wrap around instead of saturating:
  - inc from DUTY_MAX → 0.
  - dec from 0 → DUTY_MAX.
  - Otherwise the normal ±STEP applies, clamped to DUTY_MAX.
  - duty_upd pulses on every wrap.
- Ramp-mode behaviour is unchanged.
- When not defined, manual steps saturate as described in Behaviour.

Test Plan:
- Reset: hold rst_n=0 mid-sim, then release → duty_out=5, duty_upd=0, ramp_dir=1; no change for 50 cycles with buttons idle.
- Manual step: inc_req high for 100 ns (10 clk) ×3 presses with 100 ns gaps → duty_out 5→6→7→8. Each update occurs 13 cycles after press start with one duty_upd pulse. Then 3 dec presses → 8→7→6→5.
- Debounce: inc_req pulses of 5 cycles repeated ×4 → duty_out stays 5 and duty_upd never asserts.
- Saturation: 7 inc presses from 5 → duty_out stops at 10, with exactly 5 duty_upd pulses. Same check for 0 on the low side. With PWM_DUTY_WRAP_EN, the 6th press gives 0.
- Simultaneous: inc_req and dec_req asserted on the same edge for 20 cycles → duty_out unchanged, no duty_upd.
- Ramp: RAMP_DIV=4, ramp_en=1 from duty 5 → duty increments every 4 cycles to 10, then ramp_dir=0 and it decrements to 0, then ramp_dir=1. Presses during the ramp are ignored. ramp_en=0 at duty 3 → holds 3.
